// File: rtl/hazard_stall_controller.sv
// Hazard sequencer for the 5-stage RV32I pipeline: load-use bubbles, taken-branch
// flushes and fixed-latency MUL/DIV front-end freeze, plus stall/flush counters.
module hazard_stall_controller #(
  parameter int MULDIV_LATENCY = 4,
  parameter int STALL_CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4:0]             IF_ID_rs1,
  input  logic [4:0]             IF_ID_rs2,
  input  logic                   IF_ID_uses_rs2,
  input  logic [4:0]             ID_EX_rd,
  input  logic                   ID_EX_MemRead,
  input  logic                   ID_EX_is_muldiv,
  input  logic                   EX_branch_taken,
  output logic                   PC_Write,
  output logic                   IF_ID_Write,
  output logic                   IF_ID_Flush,
  output logic                   ID_EX_Flush,
  output logic                   EX_Hold,
  output logic                   muldiv_start,
  output logic                   busy,
  output logic [STALL_CNT_W-1:0] stall_cycles,
  output logic [7:0]             flush_count
);

  typedef enum logic {RUN, MD_BUSY} state_t;

  // md_cnt counts the remaining held cycles after the start cycle; 0 marks the release cycle.
  localparam logic [3:0] MD_INIT = 4'(MULDIV_LATENCY - 2);

  state_t     state, next_state;
  logic [3:0] md_cnt, next_md_cnt;
  logic       flush_inc;
  logic       load_use;

  assign load_use = ID_EX_MemRead && (ID_EX_rd != 5'd0) &&
                    ((ID_EX_rd == IF_ID_rs1) ||
                     (IF_ID_uses_rs2 && (ID_EX_rd == IF_ID_rs2)));

  assign busy = (state == MD_BUSY);

  always_comb begin
    PC_Write     = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Flush  = 1'b0;
    EX_Hold      = 1'b0;
    muldiv_start = 1'b0;
    next_state   = state;
    next_md_cnt  = md_cnt;
    flush_inc    = 1'b0;

    if (rst) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (EX_branch_taken) begin
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
            flush_inc   = 1'b1;
          end else if (ID_EX_is_muldiv) begin
            muldiv_start = 1'b1;
            EX_Hold      = 1'b1;
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            next_state   = MD_BUSY;
            next_md_cnt  = MD_INIT;
          end else if (load_use) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
          end
        end
        MD_BUSY: begin
          PC_Write    = 1'b0;
          IF_ID_Write = 1'b0;
          if (md_cnt != 4'd0) begin
            EX_Hold     = 1'b1;
            next_md_cnt = md_cnt - 4'd1;
          end else begin
            // Result leaves EX; a bubble backfills it while the front end is still frozen.
            ID_EX_Flush = 1'b1;
            next_state  = RUN;
          end
        end
        default: next_state = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      md_cnt       <= 4'd0;
      stall_cycles <= '0;
      flush_count  <= 8'd0;
    end else begin
      state  <= next_state;
      md_cnt <= next_md_cnt;
      if (!PC_Write && (stall_cycles != {STALL_CNT_W{1'b1}}))
        stall_cycles <= stall_cycles + STALL_CNT_W'(1);
      if (flush_inc)
        flush_count <= flush_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller; a second instance with a 4-bit stall
// counter shares the inputs to exercise counter saturation.
module tb_hazard_stall_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  IF_ID_rs1, IF_ID_rs2, ID_EX_rd;
  logic        IF_ID_uses_rs2, ID_EX_MemRead, ID_EX_is_muldiv, EX_branch_taken;
  logic        PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_Hold, muldiv_start, busy;
  logic [15:0] stall_cycles;
  logic [7:0]  flush_count;

  logic        s_PC_Write, s_IF_ID_Write, s_IF_ID_Flush, s_ID_EX_Flush, s_EX_Hold;
  logic        s_muldiv_start, s_busy;
  logic [3:0]  s_stall_cycles;
  logic [7:0]  s_flush_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  hazard_stall_controller #(.MULDIV_LATENCY(4), .STALL_CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2), .IF_ID_uses_rs2(IF_ID_uses_rs2),
    .ID_EX_rd(ID_EX_rd), .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_is_muldiv(ID_EX_is_muldiv),
    .EX_branch_taken(EX_branch_taken),
    .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
    .ID_EX_Flush(ID_EX_Flush), .EX_Hold(EX_Hold), .muldiv_start(muldiv_start),
    .busy(busy), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  hazard_stall_controller #(.MULDIV_LATENCY(4), .STALL_CNT_W(4)) dut_s (
    .clk(clk), .rst(rst),
    .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2), .IF_ID_uses_rs2(IF_ID_uses_rs2),
    .ID_EX_rd(ID_EX_rd), .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_is_muldiv(ID_EX_is_muldiv),
    .EX_branch_taken(EX_branch_taken),
    .PC_Write(s_PC_Write), .IF_ID_Write(s_IF_ID_Write), .IF_ID_Flush(s_IF_ID_Flush),
    .ID_EX_Flush(s_ID_EX_Flush), .EX_Hold(s_EX_Hold), .muldiv_start(s_muldiv_start),
    .busy(s_busy), .stall_cycles(s_stall_cycles), .flush_count(s_flush_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled on the falling edge, inputs change just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    IF_ID_rs1 = 5'd0; IF_ID_rs2 = 5'd0; IF_ID_uses_rs2 = 1'b0;
    ID_EX_rd = 5'd0; ID_EX_MemRead = 1'b0; ID_EX_is_muldiv = 1'b0; EX_branch_taken = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pcw"},   32'(PC_Write), 32'd0);
    chk({tag, "_ifidw"}, 32'(IF_ID_Write), 32'd0);
    chk({tag, "_iff"},   32'(IF_ID_Flush), 32'd1);
    chk({tag, "_idf"},   32'(ID_EX_Flush), 32'd1);
    chk({tag, "_hold"},  32'(EX_Hold), 32'd0);
    chk({tag, "_start"}, 32'(muldiv_start), 32'd0);
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    idle_inputs();
    tick();
    settle();
    chk_reset_outputs("rst");
    tick();
    settle();
    chk("rst_stall", 32'(stall_cycles), 32'd0);
    chk("rst_flush", 32'(flush_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Idle RUN
    rst = 1'b0;
    tick();
    settle();
    chk("idle_pcw", 32'(PC_Write), 32'd1);
    chk("idle_ifidw", 32'(IF_ID_Write), 32'd1);
    chk("idle_idf", 32'(ID_EX_Flush), 32'd0);
    chk("idle_iff", 32'(IF_ID_Flush), 32'd0);

    // Load-use on rs1
    tick();
    ID_EX_MemRead = 1'b1; ID_EX_rd = 5'd5; IF_ID_rs1 = 5'd5;
    settle();
    chk("lu_pcw", 32'(PC_Write), 32'd0);
    chk("lu_ifidw", 32'(IF_ID_Write), 32'd0);
    chk("lu_idf", 32'(ID_EX_Flush), 32'd1);
    chk("lu_stall_before", 32'(stall_cycles), 32'd0);
    tick();
    idle_inputs();
    settle();
    chk("lu_after_pcw", 32'(PC_Write), 32'd1);
    chk("lu_stall_after", 32'(stall_cycles), 32'd1);

    // rd = x0 never stalls
    tick();
    ID_EX_MemRead = 1'b1; ID_EX_rd = 5'd0; IF_ID_rs1 = 5'd0;
    settle();
    chk("x0_pcw", 32'(PC_Write), 32'd1);

    // rs2 match ignored when rs2 unused, honoured when used
    tick();
    ID_EX_rd = 5'd5; IF_ID_rs1 = 5'd3; IF_ID_rs2 = 5'd5; IF_ID_uses_rs2 = 1'b0;
    settle();
    chk("rs2_unused_pcw", 32'(PC_Write), 32'd1);
    tick();
    IF_ID_uses_rs2 = 1'b1;
    settle();
    chk("rs2_used_pcw", 32'(PC_Write), 32'd0);
    chk("rs2_used_idf", 32'(ID_EX_Flush), 32'd1);
    tick();
    idle_inputs();
    settle();
    chk("rs2_stall", 32'(stall_cycles), 32'd2);

    // Taken branch overrides a coinciding load-use
    tick();
    ID_EX_MemRead = 1'b1; ID_EX_rd = 5'd7; IF_ID_rs2 = 5'd7; IF_ID_uses_rs2 = 1'b1;
    EX_branch_taken = 1'b1;
    settle();
    chk("br_iff", 32'(IF_ID_Flush), 32'd1);
    chk("br_idf", 32'(ID_EX_Flush), 32'd1);
    chk("br_pcw", 32'(PC_Write), 32'd1);
    chk("br_ifidw", 32'(IF_ID_Write), 32'd1);
    tick();
    idle_inputs();
    settle();
    chk("br_flush_count", 32'(flush_count), 32'd1);
    chk("br_stall", 32'(stall_cycles), 32'd2);

    // Branch together with muldiv: branch wins, no MD_BUSY entry
    tick();
    EX_branch_taken = 1'b1; ID_EX_is_muldiv = 1'b1;
    settle();
    chk("brmd_start", 32'(muldiv_start), 32'd0);
    chk("brmd_pcw", 32'(PC_Write), 32'd1);
    tick();
    idle_inputs();
    settle();
    chk("brmd_busy", 32'(busy), 32'd0);
    chk("brmd_flush_count", 32'(flush_count), 32'd2);

    // Single MUL, latency 4 (inputs held; ignored while busy)
    tick();
    ID_EX_is_muldiv = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk($sformatf("mul_c%0d_start", i), 32'(muldiv_start), 32'(i == 0));
      chk($sformatf("mul_c%0d_hold", i), 32'(EX_Hold), 32'(i < 3));
      chk($sformatf("mul_c%0d_pcw", i), 32'(PC_Write), 32'd0);
      chk($sformatf("mul_c%0d_ifidw", i), 32'(IF_ID_Write), 32'd0);
      chk($sformatf("mul_c%0d_idf", i), 32'(ID_EX_Flush), 32'(i == 3));
      chk($sformatf("mul_c%0d_busy", i), 32'(busy), 32'(i >= 1));
      tick();
      if (i == 2) ID_EX_is_muldiv = 1'b0;
    end
    settle();
    chk("mul_done_busy", 32'(busy), 32'd0);
    chk("mul_done_pcw", 32'(PC_Write), 32'd1);
    chk("mul_stall", 32'(stall_cycles), 32'd6);

    // Back-to-back MUL: second start exactly 4 cycles after the first
    tick();
    ID_EX_is_muldiv = 1'b1;
    for (int i = 0; i < 8; i++) begin
      settle();
      chk($sformatf("b2b_c%0d_start", i), 32'(muldiv_start), 32'((i == 0) || (i == 4)));
      chk($sformatf("b2b_c%0d_pcw", i), 32'(PC_Write), 32'd0);
      tick();
      if (i == 6) ID_EX_is_muldiv = 1'b0;
    end
    settle();
    chk("b2b_done_pcw", 32'(PC_Write), 32'd1);
    chk("b2b_stall", 32'(stall_cycles), 32'd14);

    // Reset while busy with md_cnt = 1
    tick();
    ID_EX_is_muldiv = 1'b1;
    tick();
    ID_EX_is_muldiv = 1'b0;
    tick();
    settle();
    chk("mdrst_busy_before", 32'(busy), 32'd1);
    chk("mdrst_hold_before", 32'(EX_Hold), 32'd1);
    @(posedge clk);
    rst = 1'b1;
    settle();
    chk_reset_outputs("mdrst");
    tick();
    rst = 1'b0;
    settle();
    chk("mdrst_busy", 32'(busy), 32'd0);
    chk("mdrst_stall", 32'(stall_cycles), 32'd0);
    chk("mdrst_flush", 32'(flush_count), 32'd0);
    chk("mdrst_start", 32'(muldiv_start), 32'd0);
    chk("mdrst_pcw", 32'(PC_Write), 32'd1);

    // flush_count wraps after 256 taken branches
    tick();
    EX_branch_taken = 1'b1;
    for (int i = 0; i < 255; i++) tick();
    settle();
    chk("wrap_255", 32'(flush_count), 32'd255);
    tick();
    EX_branch_taken = 1'b0;
    settle();
    chk("wrap_0", 32'(flush_count), 32'd0);
    chk("wrap_stall", 32'(stall_cycles), 32'd0);

    // Stall counter saturation on the 4-bit instance
    tick();
    ID_EX_MemRead = 1'b1; ID_EX_rd = 5'd5; IF_ID_rs1 = 5'd5;
    for (int i = 0; i < 15; i++) tick();
    settle();
    chk("sat_15", 32'(s_stall_cycles), 32'd15);
    for (int i = 0; i < 5; i++) tick();
    settle();
    chk("sat_20_small", 32'(s_stall_cycles), 32'd15);
    chk("sat_20_wide", 32'(stall_cycles), 32'd20);
    tick();
    idle_inputs();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
